sr_pulse_encoder: RTL and testbench

- Encodes a noisy asynchronous level input into clean, width-controlled set/reset pulse pairs that drive an SR latch.
- It is the opposite conversion to an SR latch, which turns S/R pulses into a level.
- Sits between raw switch/status inputs and the SR latch storage cells.
- Synchronises and debounces the input, then emits exactly one S pulse per debounced rise and one R pulse per debounced fall.

---
 rtl/sr_pulse_encoder.sv | 128 ++++++++++++
 tb/tb_sr_pulse_encoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sr_pulse_encoder.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_encoder
// Brief    : Sync + debounce a raw level, then emit one S (rise) or R (fall)
//            pulse of PW cycles to drive an SR latch.
// Revision : 1.0 - initial release
// ============================================================================
module sr_pulse_encoder #(
    parameter int DB_CYCLES = 4,
    parameter int PW        = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    input  logic EN,
    output logic S,
    output logic R,
    output logic Q_MON,
    output logic BUSY
);

    localparam int c_db_w = $clog2(DB_CYCLES + 1);
    localparam int c_pw_w = $clog2(PW + 1);

    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DB_CYCLES - 1);
    localparam logic [c_pw_w-1:0] c_pw_load = c_pw_w'(PW - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_setp = 2'd1;
    localparam logic [1:0] c_st_rstp = 2'd2;

    logic              r_sync1;
    logic              r_sync2;
    logic [c_db_w-1:0] r_db_cnt;
    logic              r_q_mon;
    logic              r_qe;
    logic [c_pw_w-1:0] r_pw_cnt;
    logic [1:0]        r_state;
    logic              r_s;
    logic              r_r;
    logic              r_busy;

    logic [1:0]        w_state_nxt;
    logic              w_qe_nxt;
    logic [c_pw_w-1:0] w_pw_cnt_nxt;
    logic              w_s_nxt;
    logic              w_r_nxt;
    logic              w_busy_nxt;

    // Synchroniser and debouncer run independently of EN and of the FSM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            r_q_mon  <= 1'b0;
        end else begin
            r_sync1 <= D;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_q_mon) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_q_mon  <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // State register; outputs are registered from the next-state decode so
    // they change on the same edge as the state and never glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= c_st_idle;
            r_qe     <= 1'b0;
            r_pw_cnt <= '0;
            r_s      <= 1'b0;
            r_r      <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_qe     <= w_qe_nxt;
            r_pw_cnt <= w_pw_cnt_nxt;
            r_s      <= w_s_nxt;
            r_r      <= w_r_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_qe_nxt     = r_qe;
        w_pw_cnt_nxt = r_pw_cnt;
        case (r_state)
            c_st_idle: begin
                if (EN && (r_q_mon != r_qe)) begin
                    w_qe_nxt     = r_q_mon;
                    w_pw_cnt_nxt = c_pw_load;
                    w_state_nxt  = r_q_mon ? c_st_setp : c_st_rstp;
                end
            end
            c_st_setp, c_st_rstp: begin
                if (r_pw_cnt == '0) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_pw_cnt_nxt = r_pw_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_s_nxt    = (w_state_nxt == c_st_setp);
        w_r_nxt    = (w_state_nxt == c_st_rstp);
        w_busy_nxt = w_s_nxt | w_r_nxt;
    end

    assign S     = r_s;
    assign R     = r_r;
    assign BUSY  = r_busy;
    assign Q_MON = r_q_mon;

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_pulse_encoder
// Brief    : Directed vector table for the default encoder plus hand-written
//            sequences for a PW=8/DB_CYCLES=1 instance and reset mid-pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_pulse_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d1  = 1'b0;
    logic en1 = 1'b1;
    logic d2  = 1'b0;
    logic en2 = 1'b1;
    logic s1, r1, q1, b1;
    logic s2, r2, q2, b2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic d;
        logic en;
        logic [3:0] exp;   // {S, R, Q_MON, BUSY}
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sr_pulse_encoder u_dut1 (
        .CLK(clk), .RST(rst), .D(d1), .EN(en1),
        .S(s1), .R(r1), .Q_MON(q1), .BUSY(b1)
    );

    sr_pulse_encoder #(.DB_CYCLES(1), .PW(8)) u_dut2 (
        .CLK(clk), .RST(rst), .D(d2), .EN(en2),
        .S(s2), .R(r2), .Q_MON(q2), .BUSY(b2)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic d, input logic en, input logic [3:0] exp, input int n);
        vec_t v;
        v.d = d;
        v.en = en;
        v.exp = exp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        // Default instance, one row per clock edge: {S,R,Q_MON,BUSY}.
        // Rise 0->1.
        add(1, 1, 4'b0000, 5);
        add(1, 1, 4'b0010, 1);
        add(1, 1, 4'b1011, 2);
        add(1, 1, 4'b0010, 4);
        // Fall 1->0.
        add(0, 1, 4'b0010, 5);
        add(0, 1, 4'b0000, 1);
        add(0, 1, 4'b0101, 2);
        add(0, 1, 4'b0000, 4);
        // Three back-to-back 3-cycle glitches.
        for (int g = 0; g < 3; g++) begin
            add(1, 1, 4'b0000, 3);
            add(0, 1, 4'b0000, 1);
        end
        add(0, 1, 4'b0000, 4);
        // EN low while the level settles, then enable and toggle.
        add(1, 0, 4'b0000, 5);
        add(1, 0, 4'b0010, 3);
        add(1, 1, 4'b1011, 2);
        add(1, 0, 4'b0010, 1);
        add(1, 1, 4'b0010, 1);
        add(1, 0, 4'b0010, 1);
        add(1, 1, 4'b0010, 1);
        add(1, 0, 4'b0010, 1);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut1", {s1, r1, q1, b1}, 4'b0000);
        chk("reset_dut2", {s2, r2, q2, b2}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_idle", {s1, r1, q1, b1}, 4'b0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            d1  = vecs[i].d;
            en1 = vecs[i].en;
            @(posedge clk);
            #1;
            chk($sformatf("vec[%0d]", i), {s1, r1, q1, b1}, vecs[i].exp);
        end

        // PW=8, DB=1: rise then fall 3 cycles later -> full S, idle gap, full R.
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            d2 = (c <= 3);
            @(posedge clk);
            #1;
            chk($sformatf("pw8_risefall c%0d", c), {2'b00, s2, r2},
                {2'b00, (c >= 4 && c <= 11), (c >= 13 && c <= 20)});
            chk($sformatf("pw8_excl c%0d", c), {3'b000, s2 & r2}, 4'b0000);
        end

        // PW=8, DB=1: level dips and recovers inside the S pulse -> no R pulse.
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            d2 = !(c == 6 || c == 7);
            @(posedge clk);
            #1;
            chk($sformatf("pw8_revert c%0d", c), {2'b00, s2, r2},
                {2'b00, (c >= 4 && c <= 11), 1'b0});
            if (c == 8)  chk("pw8_revert_qdip", {3'b000, q2}, 4'b0000);
            if (c == 10) chk("pw8_revert_qback", {3'b000, q2}, 4'b0001);
        end

        // Reset in the first cycle of an S pulse, then a fresh pulse.
        @(negedge clk);
        rst = 1'b1;
        d1  = 1'b1;
        en1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pre_rst_pulse c%0d", c), {s1, b1}, (c == 7) ? 4'b0011 : 4'b0000);
        end
        rst = 1'b1;
        #1;
        chk("async_rst_truncate", {s1, r1, q1, b1}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_pulse c%0d", c), {s1, r1, q1, b1},
                {(c == 7 || c == 8), 1'b0, (c >= 6), (c == 7 || c == 8)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
